// File: rtl/mem_port_arbiter_if.sv
// Bundle of the three requester channels (fetch, load/store, debug) and both
// memory ports seen by mem_port_arbiter. The arbiter uses the slave modport.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;

  logic [ADDR_W-1:0] mem_address_a;
  logic [DATA_W-1:0] mem_data_a;
  logic              mem_wren_a;
  logic [DATA_W-1:0] mem_q_a;
  logic [ADDR_W-1:0] mem_address_b;
  logic [DATA_W-1:0] mem_data_b;
  logic              mem_wren_b;
  logic [DATA_W-1:0] mem_q_b;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  ls_req, ls_we, ls_addr, ls_wdata,
    output ls_gnt, ls_rvalid, ls_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_address_a, mem_data_a, mem_wren_a,
    input  mem_q_a,
    output mem_address_b, mem_data_b, mem_wren_b,
    input  mem_q_b
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output ls_req, ls_we, ls_addr, ls_wdata,
    input  ls_gnt, ls_rvalid, ls_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_address_a, mem_data_a, mem_wren_a,
    output mem_q_a,
    input  mem_address_b, mem_data_b, mem_wren_b,
    output mem_q_b
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Front end of the dual-port instruction/data memory: port B belongs to
// load/store, port A is shared by fetch and debug with a starvation override.
module mem_port_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic                clk,
  input logic                rst_n,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

  logic [3:0]        starve_cnt;
  logic              cand_if;
  logic              cand_dbg;
  logic              cand_we;
  logic [ADDR_W-1:0] cand_addr;
  logic              hazard;
  logic              if_rvalid_q;
  logic              dbg_rvalid_q;
  logic              ls_rvalid_q;

  // Fetch normally wins port A; debug wins once it has waited STARVE_MAX cycles.
  // A hazard stalls the candidate rather than handing port A to the other side,
  // so an access is never reordered around a same-address load/store.
  always_comb begin
    // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
    cand_dbg  = bus.dbg_req && (!bus.if_req || (starve_cnt == STARVE_LIMIT));
    cand_if   = bus.if_req && !cand_dbg;
    cand_addr = cand_dbg ? bus.dbg_addr : bus.if_addr;
    cand_we   = cand_dbg && bus.dbg_we;
    hazard    = (cand_if || cand_dbg) && bus.ls_req &&
                (cand_addr == bus.ls_addr) && (cand_we || bus.ls_we);
  end

  assign bus.ls_gnt  = rst_n && bus.ls_req;
  assign bus.if_gnt  = rst_n && cand_if  && !hazard;
  assign bus.dbg_gnt = rst_n && cand_dbg && !hazard;

  assign bus.mem_address_a = bus.if_gnt  ? bus.if_addr  :
                             bus.dbg_gnt ? bus.dbg_addr : '0;
  assign bus.mem_data_a    = bus.dbg_gnt ? bus.dbg_wdata : '0;
  assign bus.mem_wren_a    = bus.dbg_gnt && bus.dbg_we;

  assign bus.mem_address_b = bus.ls_gnt ? bus.ls_addr  : '0;
  assign bus.mem_data_b    = bus.ls_gnt ? bus.ls_wdata : '0;
  assign bus.mem_wren_b    = bus.ls_gnt && bus.ls_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      starve_cnt <= '0;
    end else if (bus.dbg_gnt || !bus.dbg_req) begin
      starve_cnt <= '0;
    end else if (starve_cnt < STARVE_LIMIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Memory returns q one cycle after the address, so each accepted read
  // raises its rvalid for exactly the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rvalid_q  <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      ls_rvalid_q  <= 1'b0;
    end else begin
      if_rvalid_q  <= bus.if_gnt;
      dbg_rvalid_q <= bus.dbg_gnt && !bus.dbg_we;
      ls_rvalid_q  <= bus.ls_gnt  && !bus.ls_we;
    end
  end

  assign bus.if_rvalid  = if_rvalid_q;
  assign bus.dbg_rvalid = dbg_rvalid_q;
  assign bus.ls_rvalid  = ls_rvalid_q;
  assign bus.if_rdata   = bus.mem_q_a;
  assign bus.dbg_rdata  = bus.mem_q_a;
  assign bus.ls_rdata   = bus.mem_q_b;

endmodule
